fifo_param: RTL
===============

# fifo_param

Parametrised synchronous FIFO, the next generation of the team's fixed 20-bit FIFO. It adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer blocks in the same clock domain as a drop-in buffer.

## Interface
- WIDTH, 20, data word width in bits.
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- FWFT, 0, read mode: 0 = standard (registered read); 1 = first-word-fall-through.
- OUT_HIZ, 1, 1 = data_out driven to all-Z whenever data_valid=0; 0 = data_out holds its last value.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of contents.
- write  in  1  push request.
- data_in  in  WIDTH  push data.
- read  in  1  pop request.
- data_out  out  WIDTH  pop data.
- data_valid  out  1  data_out carries a valid word.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_LEVEL.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clear_err  in  1  synchronous clear of overflow and underflow.

## Operation
- Storage: DEPTH x WIDTH array. Read and write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. count is tracked in its own register, not derived from the pointers.
- Write accepted iff write=1 and (full=0, or read is accepted in the same cycle). A rejected write sets overflow and leaves array, pointer and count unchanged.
- Read accepted iff read=1 and empty=0. A read on an empty FIFO is rejected and sets underflow, even if a write is accepted in the same cycle.
- Simultaneous accepted read and write: both pointers advance and count is unchanged. This includes the full case, where the write is accepted because the read frees a slot.
- Standard mode (FWFT=0): an accepted read registers the head word into data_out at that edge. data_valid=1 for exactly the following cycle, then returns to 0 unless another read is accepted.
- FWFT mode: data_out shows the head word whenever empty=0, and data_valid = ~empty. read acknowledges the word and advances to the next entry.
- flush=1: at the next edge, pointers, count and data_valid are cleared. Flush overrides write and read in that cycle. Sticky flags and array contents are not altered.
- clear_err=1 clears overflow and underflow at the next edge. If a new error occurs in the same cycle, the flag is set; set wins over clear.
- Reset (reset_n=0, asynchronous): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, data_valid=0, overflow=0, underflow=0. data_out is Z when OUT_HIZ=1, otherwise 0. Array contents are not reset. Reset mid-transfer discards all contents immediately.

## Timing
- All status outputs are registered and update at the same edge as count. No combinational path runs from write or read to any flag.
- Write latency to empty deassertion: 1 edge.
- Standard mode: with read held high, a word written at edge N appears on data_out at edge N+1.
- FWFT mode: a word written at edge N into an empty FIFO is on data_out right after edge N. data_out is a combinational array read, registered pointer only.
- Status outputs reflect the state after an edge. A request is qualified against those registered values in the cycle it is presented.

## Test plan
- Reset: assert reset_n=0 mid-cycle with no clock edge -> all outputs take their reset values immediately, and data_out is Z (OUT_HIZ=1).
- Fill and drain (WIDTH=20, DEPTH=4, AF=3, AE=1, FWFT=0): write 0x00001, 0x00003, 0x00005, 0x0000D -> count goes 1,2,3,4; almost_full at count 3; full at 4. A fifth write of 0x3800D sets overflow with count still 4. Four reads return 0x00001, 0x00003, 0x00005, 0x0000D in order, each with a one-cycle data_valid pulse. A fifth read sets underflow.
- Full plus simultaneous read/write: at count=4, read=write=1 with 0x00AAA -> count stays 4, overflow stays 0, and 0x00AAA comes out fourth afterwards.
- Empty plus simultaneous read/write: at count=0, read=write=1 with 0x00055 -> count=1, underflow=1, data_valid=0, and the next read returns 0x00055.
- Wrap-around and FWFT: with FWFT=1, push and pop 10 words 0x00000..0x00009 one at a time -> data_out equals each word one edge after its write, with pointers wrapping twice and no loss.
- Flush and clear_err: with 3 entries and overflow=1, pulse flush together with write -> count=0, empty=1, write ignored, overflow still 1. Then pulse clear_err -> overflow=0.

Source files
------------

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost flags,
// sticky error flags, flush and selectable first-word-fall-through.
module fifo_param #(
    parameter int WIDTH    = 20,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0,
    parameter int OUT_HIZ  = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     write,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     read,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clear_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             ae_q, ae_d;
    logic             af_q, af_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             dv_q, dv_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             rd_acc, wr_acc;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] word;
    logic             vld;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        rd_acc   = read & ~empty_q;
        // a full FIFO still takes a write when the same cycle frees a slot
        wr_acc   = write & (~full_q | rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dv_d     = 1'b0;
        dout_d   = dout_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                dout_d   = head;
            end
            dv_d = rd_acc;
            if (wr_acc && !rd_acc) count_d = count_q + CW'(1);
            if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
        end
        ovf_d   = (ovf_q & ~clear_err) | (~flush & write & ~wr_acc);
        unf_d   = (unf_q & ~clear_err) | (~flush & read & ~rd_acc);
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
        ae_d    = (count_d <= CW'(AE_LEVEL));
        af_d    = (count_d >= CW'(AF_LEVEL));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dv_q     <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dv_q     <= dv_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !flush) mem_q[wr_ptr_q] <= data_in;
    end

    // FWFT shows the head live; when empty it falls back to the last word
    always_comb begin
        if (FWFT != 0) begin
            vld  = ~empty_q;
            word = empty_q ? dout_q : head;
        end else begin
            vld  = dv_q;
            word = dout_q;
        end
    end

    assign data_out     = (OUT_HIZ != 0 && !vld) ? {WIDTH{1'bz}} : word;
    assign data_valid   = vld;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
endmodule
